// File: rtl/paicore_axis_pkg.sv
// Shared definitions for the PAICORE AXI-Stream blocks: default widths,
// frame receiver state encoding and a saturating beat counter helper.
package paicore_axis_pkg;

  localparam int DATA_W_DEF = 64;
  localparam int CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DISCARD = 2'd2
  } frame_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry register slice: 1-cycle push->pop latency, full rate when pop_rdy is held.
// push_rdy is a flop (skid empty), so there is no combinational path from pop_rdy.
module axis_skid_buf #(
  parameter int W = 65
) (
  input  logic         core_clk,
  input  logic         arst_n,
  input  logic [W-1:0] push_dat,
  input  logic         push_vld,
  output logic         push_rdy,
  output logic [W-1:0] pop_dat,
  output logic         pop_vld,
  input  logic         pop_rdy
);

  logic [W-1:0] skd_dat;
  logic         skd_vld;
  logic [W-1:0] pop_dat_n;
  logic [W-1:0] skd_dat_n;
  logic         pop_vld_n;
  logic         skd_vld_n;
  logic         push_acc;
  logic         out_free;

  assign push_acc = push_vld && push_rdy;
  assign out_free = !pop_vld || pop_rdy;

  always_comb begin
    pop_dat_n = pop_dat;
    pop_vld_n = pop_vld;
    skd_dat_n = skd_dat;
    skd_vld_n = skd_vld;
    if (out_free) begin
      if (skd_vld) begin
        // Oldest beat lives in the skid; it must leave first to keep order.
        pop_dat_n = skd_dat;
        pop_vld_n = 1'b1;
        skd_vld_n = 1'b0;
        if (push_acc) begin
          skd_dat_n = push_dat;
          skd_vld_n = 1'b1;
        end
      end else if (push_acc) begin
        pop_dat_n = push_dat;
        pop_vld_n = 1'b1;
      end else begin
        pop_vld_n = 1'b0;
      end
    end else if (push_acc) begin
      skd_dat_n = push_dat;
      skd_vld_n = 1'b1;
    end
  end

  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      pop_dat  <= '0;
      pop_vld  <= 1'b0;
      skd_dat  <= '0;
      skd_vld  <= 1'b0;
      push_rdy <= 1'b0;
    end else begin
      pop_dat  <= pop_dat_n;
      pop_vld  <= pop_vld_n;
      skd_dat  <= skd_dat_n;
      skd_vld  <= skd_vld_n;
      push_rdy <= !skd_vld_n;
    end
  end

endmodule

// File: rtl/axis_frame_recv.sv
// Receives tlast-delimited frames, forwards up to max_len beats (tlast forced at the cap)
// and drops the remainder; 1-cycle latency via the skid buffer, s_axis_tready low only while it is full.
module axis_frame_recv
  import paicore_axis_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              s_axis_aclk,
  input  logic              s_axis_aresetn,
  input  logic [31:0]       max_len,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tlast,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [31:0]       beat_cnt,
  output logic [31:0]       last_len,
  output logic [CNT_W-1:0]  frame_cnt,
  output logic [CNT_W-1:0]  ovf_cnt,
  output logic              frame_done,
  output logic              ovf,
  output logic              busy
);

  localparam int SW = DATA_W + 1;

  frame_state_e state;
  frame_state_e state_n;

  logic [31:0] cap;
  logic [31:0] cap_eff;
  logic [31:0] beat_nxt;
  logic        acc;
  logic        at_cap;
  logic        fwd;
  logic        push_last;
  logic        ovf_hit;
  logic        ovf_armed;
  logic        skid_push_rdy;
  logic [SW-1:0] skid_pop_dat;

  assign acc = s_axis_tvalid && s_axis_tready;

  // The cap is latched on the first beat, so in IDLE the live max_len applies.
  assign cap_eff  = (state == IDLE) ? max_len : cap;
  assign beat_nxt = (state == IDLE) ? 32'd1 : sat_inc32(beat_cnt);
  assign at_cap   = (cap_eff != 32'd0) && (beat_nxt == cap_eff);

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    if (acc) begin
      if (s_axis_tlast) begin
        state_n = IDLE;
      end else begin
        case (state)
          IDLE, RUN: state_n = at_cap ? DISCARD : RUN;
          DISCARD:   state_n = DISCARD;
          default:   state_n = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    fwd       = 1'b0;
    push_last = 1'b0;
    ovf_hit   = 1'b0;
    case (state)
      IDLE, RUN: begin
        fwd       = acc;
        push_last = s_axis_tlast || at_cap;
      end
      DISCARD: begin
        ovf_hit = acc && ovf_armed;
      end
      default: begin
        fwd = 1'b0;
      end
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      cap        <= '0;
      beat_cnt   <= '0;
      last_len   <= '0;
      frame_cnt  <= '0;
      ovf_cnt    <= '0;
      frame_done <= 1'b0;
      ovf        <= 1'b0;
      ovf_armed  <= 1'b0;
    end else begin
      frame_done <= acc && s_axis_tlast;
      ovf        <= ovf_hit;
      if (acc) begin
        if (state == IDLE) begin
          cap <= max_len;
        end
        if (s_axis_tlast) begin
          last_len  <= beat_nxt;
          beat_cnt  <= '0;
          frame_cnt <= frame_cnt + CNT_W'(1);
        end else begin
          beat_cnt <= beat_nxt;
        end
      end
      if (ovf_hit) begin
        ovf_cnt <= ovf_cnt + CNT_W'(1);
      end
      // Armed by a capped beat without tlast; the next accepted beat is the first drop.
      if (acc && (state != DISCARD) && at_cap && !s_axis_tlast) begin
        ovf_armed <= 1'b1;
      end else if (ovf_hit || (acc && s_axis_tlast)) begin
        ovf_armed <= 1'b0;
      end
    end
  end

  axis_skid_buf #(
    .W (SW)
  ) u_skid (
    .core_clk (s_axis_aclk),
    .arst_n   (s_axis_aresetn),
    .push_dat ({push_last, s_axis_tdata}),
    .push_vld (fwd),
    .push_rdy (skid_push_rdy),
    .pop_dat  (skid_pop_dat),
    .pop_vld  (m_axis_tvalid),
    .pop_rdy  (m_axis_tready)
  );

  // Discarded beats never enter the skid, but still wait for room to keep one ready flop.
  assign s_axis_tready = skid_push_rdy;
  assign m_axis_tdata  = skid_pop_dat[DATA_W-1:0];
  assign m_axis_tlast  = skid_pop_dat[DATA_W];

endmodule

// File: tb/tb_axis_frame_recv.sv
// Directed bench for axis_frame_recv: caps, overflow, reset, backpressure and
// pulse coincidence, each scenario checked inline against hand-derived values.
module tb_axis_frame_recv;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] max_len = 32'd0;
  logic [63:0] s_tdata = 64'd0;
  logic        s_tlast = 1'b0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic [63:0] m_tdata;
  logic        m_tlast;
  logic        m_tvalid;
  logic        m_tready;
  logic [31:0] beat_cnt;
  logic [31:0] last_len;
  logic [15:0] frame_cnt;
  logic [15:0] ovf_cnt;
  logic        frame_done;
  logic        ovf;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;
  int rmode = 0;
  bit chk_rdy = 1'b0;

  // monitor state
  logic [64:0] out_q[$];
  int          out_cyc[$];
  int          cyc = 0;
  int          ovf_n, done_n, both_n, stab_err, rdy_err;
  logic [31:0] ovf_at;
  bit          prev_hold;
  logic [64:0] prev_dat;

  axis_frame_recv dut (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rst_n),
    .max_len        (max_len),
    .s_axis_tdata   (s_tdata),
    .s_axis_tlast   (s_tlast),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tready  (s_tready),
    .m_axis_tdata   (m_tdata),
    .m_axis_tlast   (m_tlast),
    .m_axis_tvalid  (m_tvalid),
    .m_axis_tready  (m_tready),
    .beat_cnt       (beat_cnt),
    .last_len       (last_len),
    .frame_cnt      (frame_cnt),
    .ovf_cnt        (ovf_cnt),
    .frame_done     (frame_done),
    .ovf            (ovf),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0: m_tready = 1'b1;
        1: m_tready = ~m_tready;
        default: m_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Signals are stable at the falling edge; record what the next rising edge will do.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      out_q.delete();
      out_cyc.delete();
      ovf_n = 0; done_n = 0; both_n = 0; stab_err = 0; rdy_err = 0;
      ovf_at = 32'd0; prev_hold = 1'b0; prev_dat = '0;
    end else begin
      if (prev_hold && (!m_tvalid || {m_tlast, m_tdata} !== prev_dat)) stab_err++;
      if (chk_rdy && !s_tready && !m_tvalid) rdy_err++;
      if (m_tvalid && m_tready) begin
        out_q.push_back({m_tlast, m_tdata});
        out_cyc.push_back(cyc);
      end
      if (ovf) begin ovf_n++; ovf_at = beat_cnt; end
      if (frame_done) done_n++;
      if (ovf && frame_done) both_n++;
      prev_hold = m_tvalid && !m_tready;
      prev_dat  = {m_tlast, m_tdata};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 64'd0;
    rst_n = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic drive_beat(input logic [63:0] d, input logic l, input int gap);
    int t = 0;
    s_tvalid = 1'b0;
    repeat (gap) step();
    s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
    while (!s_tready && t < 200) begin
      step();
      t++;
    end
    if (t >= 200) begin
      n_chk++; n_fail++;
      $display("FAIL drive_beat timeout: s_axis_tready stuck 0 for %0d cycles, need 1", t);
    end else begin
      step();
    end
    s_tvalid = 1'b0;
  endtask

  task automatic wait_out(input int n);
    int t = 0;
    while (out_q.size() < n && t < 1000) begin
      step();
      t++;
    end
    if (t >= 1000) begin
      n_chk++; n_fail++;
      $display("FAIL wait_out timeout: got %0d beats, need %0d", out_q.size(), n);
    end
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({s_tready, m_tvalid, m_tlast, busy, frame_done, ovf} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b, need 000000", {s_tready, m_tvalid, m_tlast, busy, frame_done, ovf});
    end
    n_chk++;
    if ({beat_cnt, last_len, frame_cnt, ovf_cnt} !== 96'd0 || m_tdata !== 64'd0) begin
      n_fail++; $display("FAIL reset_counters: got %h/%h, need 0", {beat_cnt, last_len, frame_cnt, ovf_cnt}, m_tdata);
    end
    repeat (2) step();
    rst_n = 1'b1;
    n_chk++;
    if (s_tready !== 1'b0) begin n_fail++; $display("FAIL ready_at_release: got %b, need 0", s_tready); end
    step();
    n_chk++;
    if (s_tready !== 1'b1) begin n_fail++; $display("FAIL ready_after_release: got %b, need 1", s_tready); end
  endtask

  task automatic test_unlimited();
    do_reset();
    max_len = 32'd0; rmode = 0;
    for (int i = 0; i < 8; i++) drive_beat(64'h100 + 64'(i), (i == 7), 0);
    wait_out(8);
    n_chk++;
    if (out_q.size() !== 8) begin n_fail++; $display("FAIL unl_count: got %0d, need 8", out_q.size()); end
    for (int i = 0; i < 8 && i < out_q.size(); i++) begin
      n_chk++;
      if (out_q[i] !== {(i == 7), 64'h100 + 64'(i)}) begin
        n_fail++; $display("FAIL unl_beat%0d: got %h, need %h", i, out_q[i], {(i == 7), 64'h100 + 64'(i)});
      end
    end
    n_chk++;
    if (out_cyc.size() == 8 && out_cyc[7] - out_cyc[0] != 7) begin
      n_fail++; $display("FAIL unl_throughput: span %0d cycles, need 7", out_cyc[7] - out_cyc[0]);
    end
    n_chk++;
    if ({last_len, frame_cnt, ovf_cnt, beat_cnt, busy} !== {32'd8, 16'd1, 16'd0, 32'd0, 1'b0}) begin
      n_fail++; $display("FAIL unl_stats: got len=%0d fr=%0d ovf=%0d bc=%0d busy=%b, need 8 1 0 0 0",
                         last_len, frame_cnt, ovf_cnt, beat_cnt, busy);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    max_len = 32'd4; rmode = 0;
    for (int i = 0; i < 10; i++) begin
      drive_beat(64'h200 + 64'(i), (i == 9), 0);
      if (i == 5) begin
        n_chk++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL ovf_busy_mid: got %b, need 1", busy); end
      end
    end
    wait_out(4);
    n_chk++;
    if (out_q.size() !== 4) begin n_fail++; $display("FAIL ovf_count: got %0d, need 4", out_q.size()); end
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      n_chk++;
      if (out_q[i] !== {(i == 3), 64'h200 + 64'(i)}) begin
        n_fail++; $display("FAIL ovf_beat%0d: got %h, need %h", i, out_q[i], {(i == 3), 64'h200 + 64'(i)});
      end
    end
    n_chk++;
    if (ovf_n !== 1 || ovf_at !== 32'd5) begin
      n_fail++; $display("FAIL ovf_pulse: got %0d pulses at beat %0d, need 1 at 5", ovf_n, ovf_at);
    end
    n_chk++;
    if ({last_len, ovf_cnt, frame_cnt, busy} !== {32'd10, 16'd1, 16'd1, 1'b0}) begin
      n_fail++; $display("FAIL ovf_stats: got len=%0d ovf=%0d fr=%0d busy=%b, need 10 1 1 0",
                         last_len, ovf_cnt, frame_cnt, busy);
    end
  endtask

  task automatic test_exact_cap();
    do_reset();
    max_len = 32'd4; rmode = 0;
    for (int i = 0; i < 4; i++) drive_beat(64'h300 + 64'(i), (i == 3), 0);
    repeat (2) step();
    n_chk++;
    if (last_len !== 32'd4) begin n_fail++; $display("FAIL exact_len4: got %0d, need 4", last_len); end
    drive_beat(64'h3AA, 1'b1, 0);
    wait_out(5);
    n_chk++;
    if ({last_len, frame_cnt, ovf_cnt} !== {32'd1, 16'd2, 16'd0} || ovf_n !== 0) begin
      n_fail++; $display("FAIL exact_stats: got len=%0d fr=%0d ovf=%0d pulses=%0d, need 1 2 0 0",
                         last_len, frame_cnt, ovf_cnt, ovf_n);
    end
    n_chk++;
    if (out_q.size() !== 5 || out_q[3] !== {1'b1, 64'h303} || out_q[4] !== {1'b1, 64'h3AA} ||
        out_q[2] !== {1'b0, 64'h302}) begin
      n_fail++; $display("FAIL exact_beats: got n=%0d b2=%h b3=%h, need 5 0_302 1_303", out_q.size(), out_q[2], out_q[3]);
    end
  endtask

  task automatic test_backpressure();
    int lens[5] = '{3, 1, 7, 2, 5};
    logic [64:0] exp_q[$];
    logic [63:0] d;
    do_reset();
    max_len = 32'd0; rmode = 1; chk_rdy = 1'b1;
    for (int f = 0; f < 5; f++) begin
      if (f == 3) rmode = 2;
      for (int b = 0; b < lens[f]; b++) begin
        d = 64'h4000 + 64'(f * 16 + b);
        exp_q.push_back({(b == lens[f] - 1), d});
        drive_beat(d, (b == lens[f] - 1), $urandom_range(0, 2));
      end
    end
    wait_out(18);
    rmode = 0; chk_rdy = 1'b0;
    n_chk++;
    if (out_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL bp_count: got %0d, need %0d", out_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
      n_chk++;
      if (out_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_beat%0d: got %h, need %h", i, out_q[i], exp_q[i]); end
    end
    n_chk++;
    if (stab_err !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes while stalled, need 0", stab_err); end
    n_chk++;
    if (rdy_err !== 0) begin n_fail++; $display("FAIL bp_ready: got %0d cycles not-ready with skid not full, need 0", rdy_err); end
    n_chk++;
    if (frame_cnt !== 16'd5) begin n_fail++; $display("FAIL bp_frames: got %0d, need 5", frame_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    max_len = 32'd0; rmode = 0;
    for (int i = 0; i < 3; i++) drive_beat(64'h500 + 64'(i), 1'b0, 0);
    n_chk++;
    if (beat_cnt !== 32'd3 || busy !== 1'b1) begin
      n_fail++; $display("FAIL mid_pre: got bc=%0d busy=%b, need 3 1", beat_cnt, busy);
    end
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({m_tvalid, s_tready, busy, frame_done, ovf} !== 5'b0 || beat_cnt !== 32'd0 || m_tdata !== 64'd0) begin
      n_fail++; $display("FAIL mid_reset: got flags=%b bc=%0d data=%h, need 0", {m_tvalid, s_tready, busy, frame_done, ovf},
                         beat_cnt, m_tdata);
    end
    repeat (2) step();
    rst_n = 1'b1;
    step();
    drive_beat(64'h5A0, 1'b0, 0);
    drive_beat(64'h5A1, 1'b1, 0);
    wait_out(2);
    n_chk++;
    if (out_q.size() !== 2 || out_q[0] !== {1'b0, 64'h5A0} || out_q[1] !== {1'b1, 64'h5A1}) begin
      n_fail++; $display("FAIL mid_beats: got n=%0d b0=%h, need 2 0_5a0", out_q.size(), out_q[0]);
    end
    n_chk++;
    if (last_len !== 32'd2 || frame_cnt !== 16'd1 || done_n !== 1) begin
      n_fail++; $display("FAIL mid_stats: got len=%0d fr=%0d done=%0d, need 2 1 1", last_len, frame_cnt, done_n);
    end
  endtask

  task automatic test_max_len_change();
    do_reset();
    max_len = 32'd2; rmode = 0;
    drive_beat(64'h600, 1'b0, 0);
    max_len = 32'd8;
    for (int i = 1; i < 5; i++) drive_beat(64'h600 + 64'(i), (i == 4), 0);
    wait_out(2);
    n_chk++;
    if (out_q.size() !== 2 || out_q[0] !== {1'b0, 64'h600} || out_q[1] !== {1'b1, 64'h601}) begin
      n_fail++; $display("FAIL chg_beats: got n=%0d b1=%h, need 2 1_601", out_q.size(), out_q[1]);
    end
    n_chk++;
    if (ovf_cnt !== 16'd1 || last_len !== 32'd5) begin
      n_fail++; $display("FAIL chg_stats1: got ovf=%0d len=%0d, need 1 5", ovf_cnt, last_len);
    end
    for (int i = 0; i < 5; i++) drive_beat(64'h610 + 64'(i), (i == 4), 0);
    wait_out(7);
    n_chk++;
    if (out_q.size() !== 7 || out_q[6] !== {1'b1, 64'h614} || out_q[2] !== {1'b0, 64'h610}) begin
      n_fail++; $display("FAIL chg_beats2: got n=%0d b6=%h, need 7 1_614", out_q.size(), out_q[6]);
    end
    n_chk++;
    if (ovf_cnt !== 16'd1 || frame_cnt !== 16'd2) begin
      n_fail++; $display("FAIL chg_stats2: got ovf=%0d fr=%0d, need 1 2", ovf_cnt, frame_cnt);
    end
  endtask

  task automatic test_cap_one();
    do_reset();
    max_len = 32'd1; rmode = 0;
    drive_beat(64'h700, 1'b1, 0);
    drive_beat(64'h710, 1'b0, 0);
    drive_beat(64'h711, 1'b1, 0);
    wait_out(2);
    n_chk++;
    if (out_q.size() !== 2 || out_q[0] !== {1'b1, 64'h700} || out_q[1] !== {1'b1, 64'h710}) begin
      n_fail++; $display("FAIL cap1_beats: got n=%0d b1=%h, need 2 1_710", out_q.size(), out_q[1]);
    end
    n_chk++;
    if (ovf_n !== 1 || both_n !== 1 || ovf_cnt !== 16'd1) begin
      n_fail++; $display("FAIL cap1_pulses: got ovf=%0d both=%0d cnt=%0d, need 1 1 1", ovf_n, both_n, ovf_cnt);
    end
    n_chk++;
    if (last_len !== 32'd2 || frame_cnt !== 16'd2 || done_n !== 2) begin
      n_fail++; $display("FAIL cap1_stats: got len=%0d fr=%0d done=%0d, need 2 2 2", last_len, frame_cnt, done_n);
    end
  endtask

  initial begin
    test_reset();
    test_unlimited();
    test_overflow();
    test_exact_cap();
    test_backpressure();
    test_reset_mid_frame();
    test_max_len_change();
    test_cap_one();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_frame_recv.md
Name: axis_frame_recv

Overview:
- Receive-side counterpart to the tlast-insertion path: consumes a tlast-delimited 64-bit AXI-Stream frame from the host DMA (MM2S) and forwards the payload toward the PAICORE datapath.
- Enforces a maximum frame length: beats beyond `max_len` are discarded up to the input tlast.
- Reports the true received length, frame and overflow counts.
- Output is registered through a 2-entry skid buffer, so `s_axis_tready` is a flop with no combinational path from `m_axis_tready`.

Parameters:
- `DATA_W`, 64, stream data width
- `CNT_W`, 16, width of the frame and overflow counters

Ports:
- `s_axis_aclk`  in  1  clock
- `s_axis_aresetn`  in  1  asynchronous active-low reset
- `max_len`  in  32  maximum beats forwarded per frame; 0 = unlimited; sampled at first beat of each frame
- `s_axis_tdata`  in  DATA_W  input data
- `s_axis_tlast`  in  1  input end of frame
- `s_axis_tvalid`  in  1  input valid
- `s_axis_tready`  out  1  input ready (registered)
- `m_axis_tdata`  out  DATA_W  output data
- `m_axis_tlast`  out  1  output end of frame (input tlast, or forced at cap)
- `m_axis_tvalid`  out  1  output valid (registered)
- `m_axis_tready`  in  1  output ready
- `beat_cnt`  out  32  beats accepted so far in current frame
- `last_len`  out  32  total beats of last completed frame, discarded beats included
- `frame_cnt`  out  CNT_W  completed input frames
- `ovf_cnt`  out  CNT_W  frames that exceeded `max_len`
- `frame_done`  out  1  1-cycle pulse when input tlast accepted
- `ovf`  out  1  1-cycle pulse on first discarded beat of a frame
- `busy`  out  1  state != IDLE

Behaviour:
- Reset (async, active-low), all outputs 0:
  - `m_axis_tvalid` = 0, `s_axis_tready` = 0 during reset, 1 on first clock after release.
  - Counters and `last_len` = 0; state = IDLE; skid empty.
- Handshakes:
  - Input accept = `s_axis_tvalid && s_axis_tready`.
  - Output transfer = `m_axis_tvalid && m_axis_tready`.
  - Once `m_axis_tvalid` is asserted, `m_axis_tdata`/`m_axis_tlast` must not change until transfer.
- Skid buffer:
  - Output register plus one skid register; latency input accept -> `m_axis_tvalid` = 1 cycle.
  - `s_axis_tready` deasserts the cycle after the skid fills; it reasserts the cycle after the skid drains.
  - Full throughput (1 beat/cycle) when `m_axis_tready` is held high.
- FSM states:
  - IDLE: no beat of current frame accepted. On accept:
    - capture `cap = max_len`; `beat_cnt` = 1;
    - forward beat; go RUN, or stay IDLE if tlast.
  - RUN: each accept increments `beat_cnt`.
    - Beat forwarded while `cap == 0` or `beat_cnt_next <= cap`.
    - Beat number `cap` (cap != 0) is forwarded with `m_axis_tlast` = 1. If its input tlast = 0, pulse `ovf` on the next accepted beat (the first discarded one), increment `ovf_cnt`, go DISCARD.
  - DISCARD: `s_axis_tready` = 1 unless the skid is full; accepted beats are dropped and `beat_cnt` keeps counting.
- Input tlast accept (any state):
  - `last_len` = final `beat_cnt` value including this beat.
  - `frame_cnt` += 1; `frame_done` pulse; `beat_cnt` = 0; state -> IDLE.
- Boundaries:
  - Single-beat frame: IDLE -> IDLE, `last_len` = 1.
  - Frame length exactly `cap`: no `ovf`, tlast forwarded once.
  - `cap` = 1: first beat forwarded with tlast; rest discarded.
  - `max_len` changes mid-frame: no effect until next frame.
  - Counters wrap modulo 2^width silently; `beat_cnt` saturates at 0xFFFFFFFF.
  - Reset mid-frame: partial frame lost, skid cleared, no `frame_done`.
  - `ovf` and `frame_done` may pulse in the same cycle (first discarded beat carries tlast).

Decomposition:
- Shared package `paicore_axis_pkg`: `DATA_W` default, FSM state enum (IDLE/RUN/DISCARD), `CNT_W`.
- One sub-module `axis_skid_buf` (2-entry register slice, parameter DATA_W+1 for tdata+tlast). It is reusable by other stream blocks.

Test Plan:
- `max_len`=0, 8-beat frame, `m_axis_tready`=1 -> 8 beats out, tlast on beat 8, `last_len`=8, `frame_cnt`=1, `ovf_cnt`=0, throughput 1 beat/cycle.
- `max_len`=4, 10-beat frame -> 4 beats out with tlast on 4th, `ovf` pulses at input beat 5, `last_len`=10, `ovf_cnt`=1, `busy` low after beat 10.
- `max_len`=4, 4-beat frame then 1-beat frame -> no `ovf`, `last_len` 4 then 1, `frame_cnt`=2.
- `m_axis_tready` toggling 1010… / random, `s_axis_tvalid` random -> no beat lost or duplicated, data stable while stalled, `s_axis_tready` low only when skid full.
- Assert reset at beat 3 of a 6-beat frame -> all outputs 0 immediately; then a new 2-beat frame yields `last_len`=2, `frame_cnt`=1.
- `max_len` changed from 2 to 8 at beat 1 of a 5-beat frame -> cap stays 2, `ovf_cnt`=1; next 5-beat frame passes whole.
